// File: rtl/fir_uart_sequencer_if.sv
// Handshake bundle between the UART receiver/transmitter, the sequencer and the FIR core.
// The sequencer connects through the slave modport; the environment drives the master side.
interface fir_uart_sequencer_if #(
    parameter int IN_BYTES  = 2,
    parameter int OUT_BYTES = 3
);
    logic [7:0]             rx_data;
    logic                   data_ready;
    logic [8*OUT_BYTES-1:0] fir_out;
    logic                   output_valid;
    logic                   busy;
    logic [8*IN_BYTES-1:0]  fir_in;
    logic                   input_valid;
    logic [7:0]             tx_data;
    logic                   TxD_start;
    logic                   overrun;
    logic                   fir_timeout;

    modport master (
        output rx_data, data_ready, fir_out, output_valid, busy,
        input  fir_in, input_valid, tx_data, TxD_start, overrun, fir_timeout
    );

    modport slave (
        input  rx_data, data_ready, fir_out, output_valid, busy,
        output fir_in, input_valid, tx_data, TxD_start, overrun, fir_timeout
    );
endinterface

// File: rtl/fir_uart_sequencer.sv
// Collects UART bytes into FIR samples and streams FIR results back out byte by byte.
// Optional FIR watchdog is built when the macro FIR_SEQ_TIMEOUT_EN is defined.
module fir_uart_sequencer #(
    parameter int IN_BYTES       = 2,
    parameter int OUT_BYTES      = 3,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 clk,
    input logic                 rst,
    fir_uart_sequencer_if.slave bus
);
    localparam int IW = 8 * IN_BYTES;
    localparam int OW = 8 * OUT_BYTES;

    if (IN_BYTES < 1 || IN_BYTES > 8 || OUT_BYTES < 1 || OUT_BYTES > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fir_uart_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, FIR, TX_START, TX_WAIT} state_e;

    state_e        state_q, state_d;
    logic [3:0]    rx_cnt_q, rx_cnt_d, rx_cnt_inc;
    logic [3:0]    tx_cnt_q, tx_cnt_d, tx_cnt_inc;
    logic [IW-1:0] in_sr_q, in_sr_d;
    logic [OW-1:0] out_sr_q, out_sr_d, out_shifted;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          wait_armed_q, wait_armed_d;
    logic          overrun_q, overrun_d;
    logic          wd_expired;

    function automatic logic [7:0] first_byte(input logic [OW-1:0] v);
        return (MSB_FIRST != 0) ? v[OW-1 -: 8] : v[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            in_sr_q      <= '0;
            out_sr_q     <= '0;
            tx_data_q    <= '0;
            wait_armed_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            in_sr_q      <= in_sr_d;
            out_sr_q     <= out_sr_d;
            tx_data_q    <= tx_data_d;
            wait_armed_q <= wait_armed_d;
            overrun_q    <= overrun_d;
        end
    end

    // The first TX_WAIT cycle is unarmed so a transmitter that raises busy one cycle late is not missed.
    always_comb begin
        state_d      = state_q;
        rx_cnt_d     = rx_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        in_sr_d      = in_sr_q;
        out_sr_d     = out_sr_q;
        tx_data_d    = tx_data_q;
        wait_armed_d = wait_armed_q;
        overrun_d    = overrun_q;
        rx_cnt_inc   = rx_cnt_q + 4'd1;
        tx_cnt_inc   = tx_cnt_q + 4'd1;
        out_shifted  = (MSB_FIRST != 0) ? (out_sr_q << 8) : (out_sr_q >> 8);

        if (bus.data_ready && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.data_ready) begin
                    if (MSB_FIRST != 0) begin
                        in_sr_d = (in_sr_q << 8) | IW'(bus.rx_data);
                    end else begin
                        in_sr_d = (in_sr_q >> 8) | (IW'(bus.rx_data) << (IW - 8));
                    end
                    if (rx_cnt_inc == 4'(IN_BYTES)) begin
                        rx_cnt_d = '0;
                        state_d  = FIR;
                    end else begin
                        rx_cnt_d = rx_cnt_inc;
                    end
                end
            end
            FIR: begin
                if (bus.output_valid) begin
                    out_sr_d  = bus.fir_out;
                    tx_cnt_d  = '0;
                    tx_data_d = first_byte(bus.fir_out);
                    state_d   = TX_START;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            TX_START: begin
                wait_armed_d = 1'b0;
                state_d      = TX_WAIT;
            end
            TX_WAIT: begin
                if (!wait_armed_q) begin
                    wait_armed_d = 1'b1;
                end else if (!bus.busy) begin
                    out_sr_d = out_shifted;
                    tx_cnt_d = tx_cnt_inc;
                    if (tx_cnt_inc == 4'(OUT_BYTES)) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d = first_byte(out_shifted);
                        state_d   = TX_START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;

    // Counts cycles spent in FIR; any entry into FIR starts again from zero.
    always_comb begin
        wd_cnt_d  = (state_q == FIR && state_d == FIR) ? wd_cnt_q + 1'b1 : '0;
        timeout_d = timeout_q | (state_q == FIR && !bus.output_valid && wd_expired);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign wd_expired      = (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1));
    assign bus.fir_timeout = timeout_q;
`else
    assign wd_expired      = 1'b0;
    assign bus.fir_timeout = 1'b0;
`endif

    assign bus.fir_in      = in_sr_q;
    assign bus.input_valid = (state_q == FIR);
    assign bus.tx_data     = tx_data_q;
    assign bus.TxD_start   = (state_q == TX_START);
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_fir_uart_sequencer.sv
// Self-checking bench: an MSB-first and an LSB-first sequencer share one stimulus stream
// and are compared every cycle against a transaction-level model of the sequencer.
module tb_fir_uart_sequencer;
    localparam int TMO = 16;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [7:0]  rxData    = '0;
    logic        dataReady = 1'b0;
    logic [23:0] firOut    = '0;
    logic        outValid  = 1'b0;
    logic        busy      = 1'b0;

    int busyDelay = 0;
    int busyLen   = 3;
    int checks    = 0;
    int passes    = 0;

    logic [7:0] logA[$];
    logic [7:0] logB[$];

    // Model: collect/fir/transmit phases, expected samples and bytes per result index.
    bit          mFir, mTx, mPulse, mOverrun, mTimeout;
    int          mCount, mFirCycles, mWaitEdges, mSent;
    logic [7:0]  mBytes [2];
    logic [15:0] mSampA, mSampB;
    logic [23:0] mRes;
    logic [7:0]  mTxA, mTxB;

    fir_uart_sequencer_if #(.IN_BYTES(2), .OUT_BYTES(3)) busA ();
    fir_uart_sequencer_if #(.IN_BYTES(2), .OUT_BYTES(3)) busB ();

    assign busA.rx_data      = rxData;
    assign busA.data_ready   = dataReady;
    assign busA.fir_out      = firOut;
    assign busA.output_valid = outValid;
    assign busA.busy         = busy;
    assign busB.rx_data      = rxData;
    assign busB.data_ready   = dataReady;
    assign busB.fir_out      = firOut;
    assign busB.output_valid = outValid;
    assign busB.busy         = busy;

    fir_uart_sequencer #(.IN_BYTES(2), .OUT_BYTES(3), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)) dutA (
        .clk(clk), .rst(rst), .bus(busA)
    );
    fir_uart_sequencer #(.IN_BYTES(2), .OUT_BYTES(3), .MSB_FIRST(0), .TIMEOUT_CYCLES(TMO)) dutB (
        .clk(clk), .rst(rst), .bus(busB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mFir = 0; mTx = 0; mPulse = 0; mOverrun = 0; mTimeout = 0;
        mCount = 0; mFirCycles = 0; mWaitEdges = 0; mSent = 0;
        mSampA = '0; mSampB = '0; mRes = '0; mTxA = '0; mTxB = '0;
    endtask

    task automatic modelStep();
        bit collecting;
        if (rst) begin
            modelReset();
            return;
        end
        collecting = !mFir && !mTx;
        if (dataReady && !collecting) mOverrun = 1;
        if (collecting) begin
            if (dataReady) begin
                mBytes[mCount] = rxData;
                mCount++;
                if (mCount == 2) begin
                    mSampA     = {mBytes[0], mBytes[1]};
                    mSampB     = {mBytes[1], mBytes[0]};
                    mCount     = 0;
                    mFir       = 1;
                    mFirCycles = 0;
                end
            end
        end else if (mFir) begin
            if (outValid) begin
                mFir   = 0;
                mTx    = 1;
                mRes   = firOut;
                mSent  = 0;
                mPulse = 1;
            end else begin
                mFirCycles++;
`ifdef FIR_SEQ_TIMEOUT_EN
                if (mFirCycles == TMO) begin
                    mFir     = 0;
                    mTimeout = 1;
                end
`endif
            end
        end else begin
            if (mPulse) begin
                mPulse     = 0;
                mWaitEdges = 0;
            end else if (mWaitEdges == 0) begin
                mWaitEdges = 1;
            end else if (!busy) begin
                mSent++;
                if (mSent == 3) mTx = 0;
                else mPulse = 1;
            end
        end
        if (mPulse) begin
            mTxA = mRes[23 - 8*mSent -: 8];
            mTxB = mRes[8*mSent +: 8];
        end
    endtask

    task automatic compareAll();
        if (rst) modelReset();
        if (!rst && busA.TxD_start) logA.push_back(busA.tx_data);
        if (!rst && busB.TxD_start) logB.push_back(busB.tx_data);
        checkOutput("A.input_valid", 32'(busA.input_valid), 32'(mFir));
        checkOutput("B.input_valid", 32'(busB.input_valid), 32'(mFir));
        checkOutput("A.TxD_start",   32'(busA.TxD_start),   32'(mPulse));
        checkOutput("B.TxD_start",   32'(busB.TxD_start),   32'(mPulse));
        checkOutput("A.tx_data",     32'(busA.tx_data),     32'(mTxA));
        checkOutput("B.tx_data",     32'(busB.tx_data),     32'(mTxB));
        checkOutput("A.overrun",     32'(busA.overrun),     32'(mOverrun));
        checkOutput("B.overrun",     32'(busB.overrun),     32'(mOverrun));
        checkOutput("A.fir_timeout", 32'(busA.fir_timeout), 32'(mTimeout));
        checkOutput("B.fir_timeout", 32'(busB.fir_timeout), 32'(mTimeout));
        if (mFir || rst) begin
            checkOutput("A.fir_in", 32'(busA.fir_in), 32'(mSampA));
            checkOutput("B.fir_in", 32'(busB.fir_in), 32'(mSampB));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            compareAll();
        end
    end

    // Transmitter stand-in: answers each start pulse with busy after busyDelay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && busA.TxD_start) begin
                repeat (busyDelay) @(negedge clk);
                busy = 1'b1;
                repeat (busyLen) @(negedge clk);
                busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic applyByte(input logic [7:0] b);
        rxData    = b;
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
        rxData    = '0;
    endtask

    task automatic applyResult(input logic [23:0] v);
        firOut   = v;
        outValid = 1'b1;
        tick();
        outValid = 1'b0;
    endtask

    task automatic waitPulses(input int target);
        for (int i = 0; i < 300; i++) begin
            if (logA.size() >= target) break;
            tick();
        end
        checkOutput("pulse_count", 32'(logA.size()), 32'(target));
    endtask

    function automatic logic [7:0] logByte(input bit isB, input int idx);
        if (isB) return (idx < logB.size()) ? logB[idx] : 8'hxx;
        return (idx < logA.size()) ? logA[idx] : 8'hxx;
    endfunction

    task automatic applyStimulus();
        int base;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rst.A.input_valid", 32'(busA.input_valid), 32'h0);
        checkOutput("rst.A.TxD_start",   32'(busA.TxD_start),   32'h0);
        checkOutput("rst.A.tx_data",     32'(busA.tx_data),     32'h0);
        checkOutput("rst.A.fir_in",      32'(busA.fir_in),      32'h0);
        checkOutput("rst.A.overrun",     32'(busA.overrun),     32'h0);
        checkOutput("rst.B.fir_timeout", 32'(busB.fir_timeout), 32'h0);

        applyByte(8'h55);
        repeat (2) tick();
        checkOutput("one_byte.input_valid", 32'(busA.input_valid), 32'h0);
        applyReset(2);

        applyByte(8'h12);
        tick();
        applyByte(8'h34);
        checkOutput("asm.A.fir_in", 32'(busA.fir_in), 32'h1234);
        checkOutput("asm.B.fir_in", 32'(busB.fir_in), 32'h3412);
        checkOutput("asm.input_valid", 32'(busA.input_valid), 32'h1);
        checkOutput("model.sampA", 32'(mSampA), 32'h1234);
        repeat (3) tick();

        busyDelay = 0;
        base = logA.size();
        applyResult(24'hABCDEF);
        waitPulses(base + 1);
        applyByte(8'h99);
        waitPulses(base + 3);
        repeat (12) tick();
        checkOutput("tx.A0", 32'(logByte(0, base)),     32'hAB);
        checkOutput("tx.A1", 32'(logByte(0, base + 1)), 32'hCD);
        checkOutput("tx.A2", 32'(logByte(0, base + 2)), 32'hEF);
        checkOutput("tx.B0", 32'(logByte(1, base)),     32'hEF);
        checkOutput("tx.B2", 32'(logByte(1, base + 2)), 32'hAB);
        checkOutput("ovr.A.overrun", 32'(busA.overrun), 32'h1);
        checkOutput("tx.idle", 32'(busA.input_valid | busA.TxD_start), 32'h0);

        applyResult(24'h777777);
        tick();
        applyByte(8'hA5);
        applyByte(8'h5A);
        checkOutput("asm2.A.fir_in", 32'(busA.fir_in), 32'hA55A);
        checkOutput("asm2.B.fir_in", 32'(busB.fir_in), 32'h5AA5);
        busyDelay = 2;
        base = logA.size();
        applyResult(24'h010203);
        waitPulses(base + 3);
        repeat (12) tick();
        checkOutput("tx2.A1", 32'(logByte(0, base + 1)), 32'h02);
        checkOutput("tx2.B0", 32'(logByte(1, base)),     32'h03);

        base = logA.size();
        applyByte(8'h0F);
        applyByte(8'hF0);
`ifdef FIR_SEQ_TIMEOUT_EN
        repeat (TMO + 4) tick();
        checkOutput("wd.input_valid", 32'(busA.input_valid), 32'h0);
        checkOutput("wd.fir_timeout", 32'(busA.fir_timeout), 32'h1);
        checkOutput("wd.no_tx", 32'(logA.size()), 32'(base));
`else
        repeat (1000) tick();
        checkOutput("hold.input_valid", 32'(busA.input_valid), 32'h1);
        checkOutput("hold.fir_timeout", 32'(busA.fir_timeout), 32'h0);
        applyResult(24'h0A0B0C);
        waitPulses(base + 3);
        repeat (12) tick();
        checkOutput("hold.tx2", 32'(logByte(0, base + 2)), 32'h0C);
`endif

        busyDelay = 0;
        applyByte(8'h11);
        applyByte(8'h22);
        base = logA.size();
        applyResult(24'h445566);
        waitPulses(base + 2);
        tick();
        applyReset(2);
        checkOutput("mrst.TxD_start",   32'(busA.TxD_start),   32'h0);
        checkOutput("mrst.input_valid", 32'(busA.input_valid), 32'h0);
        checkOutput("mrst.tx_data",     32'(busA.tx_data),     32'h0);
        checkOutput("mrst.overrun",     32'(busA.overrun),     32'h0);
        repeat (10) tick();
        checkOutput("mrst.no_third", 32'(logA.size()), 32'(base + 2));

        applyByte(8'h77);
        applyByte(8'h88);
        checkOutput("post.A.fir_in", 32'(busA.fir_in), 32'h7788);
        base = logA.size();
        applyResult(24'hC0FFEE);
        waitPulses(base + 3);
        repeat (12) tick();
        checkOutput("post.A0", 32'(logByte(0, base)),     32'hC0);
        checkOutput("post.A2", 32'(logByte(0, base + 2)), 32'hEE);
        checkOutput("post.B0", 32'(logByte(1, base)),     32'hEE);
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fir_uart_sequencer.md
# fir_uart_sequencer

Parametrised sequencer between the UART receiver/transmitter and the FIR core. Gathers `IN_BYTES` received bytes into one input sample, holds `input_valid` until the filter answers with `output_valid`, then sends the `OUT_BYTES`-wide result back as bytes with a `busy`-paced `TxD_start` handshake. It replaces the fixed two-byte controller and adds:
- configurable sample and result widths;
- selectable byte order;
- overrun reporting;
- an optional FIR watchdog.

## Interface
Parameters:
- `IN_BYTES`, default 2: number of bytes per FIR input sample (range 1..8).
- `OUT_BYTES`, default 3: number of bytes per FIR result (range 1..8).
- `MSB_FIRST`, default 1: byte order. 1 means the first byte received or sent is the most significant. 0 means it is the least significant.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only with `FIR_SEQ_TIMEOUT_EN`.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `rx_data` input, 8 bits: received byte, valid while `data_ready` is high.
- `data_ready` input, 1 bit: single-cycle strobe from the UART receiver.
- `fir_out` input, 8·`OUT_BYTES` bits: FIR result.
- `output_valid` input, 1 bit: FIR result valid.
- `busy` input, 1 bit: UART transmitter busy.
- `fir_in` output, 8·`IN_BYTES` bits: assembled sample, registered.
- `input_valid` output, 1 bit: sample valid to the FIR.
- `tx_data` output, 8 bits: byte to transmit, registered.
- `TxD_start` output, 1 bit: one-cycle transmit start pulse.
- `overrun` output, 1 bit: sticky flag, a byte was dropped.
- `fir_timeout` output, 1 bit: sticky flag, the FIR watchdog fired.

## Operation
Reset values:
- All outputs are 0.
- State is IDLE.
- Byte counters, the watchdog counter and both shift registers are 0.

State machine:
- **IDLE**
  - On an edge where `data_ready`=1, insert `rx_data` into the input shift register:
    - `MSB_FIRST`=1: shift left, the new byte enters the LSB.
    - `MSB_FIRST`=0: shift right, the new byte enters the MSB.
  - Then increment `rx_cnt`.
  - If this byte makes `rx_cnt` equal to `IN_BYTES`: clear `rx_cnt` and go to FIR.
- **FIR**
  - `input_valid`=1 for as long as the state is held.
  - `fir_in` is stable.
  - On an edge where `output_valid`=1: load `fir_out` into the output shift register, clear `tx_cnt`, go to TX_START.
- **TX_START**
  - Load `tx_data` with the next byte (top byte if `MSB_FIRST`=1, else bottom byte).
  - `TxD_start`=1 for exactly this one cycle.
  - Go to TX_WAIT.
- **TX_WAIT**
  - The first cycle in this state ignores `busy`, which covers the transmitter's one-cycle response.
  - From the second cycle on, when `busy`=0: shift the output register by 8 and increment `tx_cnt`.
  - If `tx_cnt` reaches `OUT_BYTES`, go to IDLE; otherwise go to TX_START.

Boundary conditions:
- `data_ready`=1 in any state other than IDLE: the byte is dropped and `overrun` is set. `overrun` is cleared only by `rst`.
- `output_valid` is ignored outside FIR.
- `tx_data` changes only on entry to TX_START, so it is stable for the whole transmission.
- `rst` asserted mid-sample or mid-transmit: everything aborts at once and all state returns to its reset values. Partial bytes are discarded.
- `IN_BYTES`=1 or `OUT_BYTES`=1: the state sequence is unchanged, with a single pass through collect or transmit.

## Timing
- Last input byte's `data_ready` is sampled at edge N → `input_valid`=1 and `fir_in` final from after edge N.
- `output_valid` is sampled at edge M → `input_valid`=0 and `TxD_start`=1 in cycle M+1.
- Per result byte: 1 cycle in TX_START, plus at least 2 cycles in TX_WAIT, plus the `busy` duration.
- Minimum gap between consecutive `TxD_start` pulses: 3 cycles.
- Result sent in IDLE at cycle K → the next sample is accepted from edge K+1.

## Configuration
- `FIR_SEQ_TIMEOUT_EN` defined:
  - A counter runs while in FIR.
  - If `output_valid` has not been seen after `TIMEOUT_CYCLES` cycles in FIR: `input_valid` drops, `fir_timeout` is set (sticky until `rst`), the state returns to IDLE, and nothing is transmitted.
  - The counter clears on every entry to FIR.
- `FIR_SEQ_TIMEOUT_EN` not defined:
  - No counter is built.
  - FIR waits indefinitely for `output_valid`.
  - `fir_timeout` is tied to 0.

## Test plan
- Reset check: `rst` pulse → all outputs 0; a single `data_ready` with `IN_BYTES`=2 leaves `input_valid`=0.
- Byte assembly: `IN_BYTES`=2, `MSB_FIRST`=1, bytes 0x12 then 0x34 → `fir_in`=0x1234 and `input_valid`=1 after the second strobe; with `MSB_FIRST`=0 → 0x3412.
- Transmit: `output_valid` with `fir_out`=0xABCDEF and `OUT_BYTES`=3 → three `TxD_start` pulses with `tx_data` 0xAB, 0xCD, 0xEF. Each pulse is issued only after `busy` falls, and the sequencer then returns to IDLE.
- Overrun: `data_ready` pulsed while in TX_WAIT → byte dropped, `overrun`=1; the next sample is assembled correctly.
- Watchdog: with `FIR_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no `output_valid` → `input_valid` drops after 16 cycles, `fir_timeout`=1, no `TxD_start`. Without the macro, `input_valid` is still high after 1000 cycles.
- Mid-operation reset: `rst` between the 2nd and 3rd byte sent → `TxD_start` stays 0 and the state is IDLE. A new 2-byte sample is then processed normally.
